// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and parity helper
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_rx_state_t;

   localparam int UART_OVERSAMPLE_DEF = 16;

   // Expected parity bit for a data word; narrower words are zero-extended by the caller.
   function automatic logic uart_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// rtl/uart_bit_sync.sv - two-flop synchronizer for asynchronous single-bit inputs
module uart_bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two flops in series; reset to the line's idle level so reset never looks like an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver, 8N1 default; parity via UART_RX_PARITY_EN
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   output logic                 o_rx_frame_err,
   output logic                 o_rx_parity_err,
   output logic                 o_rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   uart_rx_state_t         r_state;
   uart_rx_state_t         w_next_state;
   logic [TW-1:0]          r_tick_cnt;
   logic [BW-1:0]          r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shreg;
   logic                   r_par_mismatch;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rx_valid;
   logic                   r_frame_err;
   logic                   r_parity_err;

   logic                   w_rx_s;
   logic                   w_mid;
   logic                   w_last;
   logic                   w_busy;
   logic                   w_shift;
   logic                   w_valid_set;
   logic                   w_ferr_set;
   logic                   w_par_sample;

   uart_bit_sync #(
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_rx),
      .o_q   (w_rx_s)
   );

   // Sample points: START decides at mid start bit; every later bit is one full period on.
   assign w_mid  = i_rx_tick && (r_tick_cnt == TICK_MID);
   assign w_last = i_rx_tick && (r_tick_cnt == TICK_LAST);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; BREAK is the only state that reacts without a tick.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (i_rx_tick && !w_rx_s) w_next_state = START;
         end
         START: begin
            if (w_mid) w_next_state = w_rx_s ? IDLE : DATA;
         end
         DATA: begin
            if (w_last && (r_bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
               w_next_state = PARITY;
`else
               w_next_state = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (w_last) w_next_state = STOP;
         end
`endif
         STOP: begin
            if (w_last) w_next_state = w_rx_s ? IDLE : BREAK;
         end
         BREAK: begin
            if (w_rx_s) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Per-state strobes that drive the datapath and output registers.
   always_comb begin
      w_busy       = (r_state != IDLE);
      w_shift      = (r_state == DATA) && w_last;
      w_par_sample = (r_state == PARITY) && w_last;
      w_valid_set  = (r_state == STOP) && w_last && w_rx_s;
      w_ferr_set   = (r_state == STOP) && w_last && !w_rx_s;
   end

   // Tick and bit counters, shift register, parity latch and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tick_cnt     <= '0;
         r_bit_cnt      <= '0;
         r_shreg        <= '0;
         r_par_mismatch <= 1'b0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_frame_err    <= 1'b0;
         r_parity_err   <= 1'b0;
      end else begin
         if ((r_state == IDLE) || (r_state == BREAK)) begin
            r_tick_cnt <= '0;
         end else if (i_rx_tick) begin
            if (((r_state == START) && (r_tick_cnt == TICK_MID)) || (r_tick_cnt == TICK_LAST)) begin
               r_tick_cnt <= '0;
            end else begin
               r_tick_cnt <= r_tick_cnt + TW'(1);
            end
         end

         if ((r_state == START) && w_mid) begin
            r_bit_cnt      <= '0;
            r_par_mismatch <= 1'b0;
         end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
         end

         if (w_shift) begin
            r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
         end

         if (w_par_sample) begin
            r_par_mismatch <= (w_rx_s != uart_parity(8'(r_shreg), PARITY_ODD));
         end

         if (w_valid_set) begin
            r_rx_data <= r_shreg;
         end

         r_rx_valid   <= w_valid_set;
         r_frame_err  <= w_ferr_set;
         r_parity_err <= PAR_EN && w_valid_set && r_par_mismatch;
      end
   end

   assign o_rx_data       = r_rx_data;
   assign o_rx_valid      = r_rx_valid;
   assign o_rx_frame_err  = r_frame_err;
   assign o_rx_parity_err = r_parity_err;
   assign o_rx_busy       = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx; parity sequences build with UART_RX_PARITY_EN
module tb_uart_rx;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_parity_err;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;

   int n_valid = 0;
   int n_ferr  = 0;
   int n_perr  = 0;
   int n_stray = 0;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         stop_len;
      int         gap;
      int         exp_valid;
      int         exp_ferr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   uart_rx #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16),
      .PARITY_ODD (1'b0)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_rx_tick       (tick),
      .i_rx            (rx),
      .o_rx_data       (rx_data),
      .o_rx_valid      (rx_valid),
      .o_rx_frame_err  (rx_frame_err),
      .o_rx_parity_err (rx_parity_err),
      .o_rx_busy       (rx_busy)
   );

   always #5 clk = ~clk;

   // rx_tick: one clk high out of every TICK_DIV.
   initial begin
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   // Pulse counters sampled on the falling edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid = n_valid + 1;
         if (rx_parity_err) n_perr = n_perr + 1;
      end else if (rx_parity_err) begin
         n_stray = n_stray + 1;
      end
      if (rx_frame_err) n_ferr = n_ferr + 1;
   end

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int n);
      rx = b;
      repeat (BIT_CLKS * n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len, input logic par);
      send_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) send_bit(d[i], 1);
`ifdef UART_RX_PARITY_EN
      send_bit(par, 1);
`else
      if (par === 1'bx) $display("parity bit undefined");
`endif
      send_bit(stop, stop_len);
   endtask

   initial begin
      int v0, f0, p0;

      vecs[0] = '{8'h55, 1'b1, 1, 1, 1, 0, 8'h55};
      vecs[1] = '{8'hA5, 1'b1, 1, 0, 1, 0, 8'hA5};
      vecs[2] = '{8'h3C, 1'b1, 1, 1, 1, 0, 8'h3C};
      vecs[3] = '{8'hFF, 1'b0, 3, 1, 0, 1, 8'h3C};
      vecs[4] = '{8'h12, 1'b1, 1, 1, 1, 0, 8'h12};
      vecs[5] = '{8'h00, 1'b1, 1, 1, 1, 0, 8'h00};
      vecs[6] = '{8'h80, 1'b1, 1, 1, 1, 0, 8'h80};
      vecs[7] = '{8'h01, 1'b1, 1, 1, 1, 0, 8'h01};

      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_data",  32'(rx_data), 32'h00);
      check("reset_valid", 32'(rx_valid), 32'd0);
      check("reset_busy",  32'(rx_busy), 32'd0);
      check("reset_ferr",  32'(rx_frame_err), 32'd0);
      check("reset_perr",  32'(rx_parity_err), 32'd0);
      rst = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      check("idle_busy", 32'(rx_busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         v0 = n_valid;
         f0 = n_ferr;
         p0 = n_perr;
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop_len, ^vecs[i].data);
         if (vecs[i].gap > 0) send_bit(1'b1, vecs[i].gap);
         check($sformatf("vec%0d_valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_ferr", i),  32'(n_ferr - f0),  32'(vecs[i].exp_ferr));
         check($sformatf("vec%0d_data", i),  32'(rx_data),      32'(vecs[i].exp_data));
         check($sformatf("vec%0d_perr", i),  32'(n_perr - p0),  32'd0);
         if (vecs[i].gap > 0) check($sformatf("vec%0d_busy", i), 32'(rx_busy), 32'd0);
      end

      // Start-bit glitch: low for 5 ticks, then high.
      v0 = n_valid;
      f0 = n_ferr;
      rx = 1'b0;
      repeat (5 * TICK_DIV) @(negedge clk);
      check("glitch_busy_start", 32'(rx_busy), 32'd1);
      rx = 1'b1;
      repeat (8 * TICK_DIV) @(negedge clk);
      check("glitch_busy_idle", 32'(rx_busy), 32'd0);
      send_bit(1'b1, 2);
      check("glitch_valid", 32'(n_valid - v0), 32'd0);
      check("glitch_ferr",  32'(n_ferr - f0),  32'd0);
      check("glitch_data",  32'(rx_data), 32'h01);

      // Reset in the middle of data bit 4 of a frame (0xF0), then a clean 0x81.
      v0 = n_valid;
      f0 = n_ferr;
      send_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1);
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      check("rst_mid_busy", 32'(rx_busy), 32'd1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send_bit(1'b1, 2);
      check("rst_after_busy",  32'(rx_busy), 32'd0);
      check("rst_after_valid", 32'(n_valid - v0), 32'd0);
      check("rst_after_ferr",  32'(n_ferr - f0), 32'd0);
      check("rst_after_data",  32'(rx_data), 32'h00);
      send_frame(8'h81, 1'b1, 1, 1'b0);
      send_bit(1'b1, 1);
      check("post_rst_valid", 32'(n_valid - v0), 32'd1);
      check("post_rst_data",  32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: even parity bit is 1.
      v0 = n_valid;
      p0 = n_perr;
      send_frame(8'h07, 1'b1, 1, 1'b1);
      send_bit(1'b1, 1);
      check("par_ok_valid", 32'(n_valid - v0), 32'd1);
      check("par_ok_perr",  32'(n_perr - p0),  32'd0);
      check("par_ok_data",  32'(rx_data), 32'h07);
      v0 = n_valid;
      p0 = n_perr;
      send_frame(8'h07, 1'b1, 1, 1'b0);
      send_bit(1'b1, 1);
      check("par_bad_valid", 32'(n_valid - v0), 32'd1);
      check("par_bad_perr",  32'(n_perr - p0),  32'd1);
      check("par_bad_data",  32'(rx_data), 32'h07);
`else
      check("no_parity_total", 32'(n_perr), 32'd0);
`endif
      check("perr_without_valid", 32'(n_stray), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
